systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder.sv | 119 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Captures an NxN operand pair and streams it diagonally skewed into the west/north
// edges of a systolic array, then drains for N cycles and pulses done.
module systolic_skew_feeder #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] MatA_i  [N][N],
    input  logic [W-1:0] MatB_i  [N][N],
    output logic         ready_o,
    output logic [W-1:0] a_row_o [N],
    output logic [W-1:0] b_col_o [N],
    output logic         valid_o,
    output logic         last_feed_o,
    output logic         done_o
);

    localparam int SW = $clog2(2 * N);
    localparam logic [SW-1:0] LAST_FEED  = SW'(2 * N - 2);
    localparam logic [SW-1:0] LAST_DRAIN = SW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_step;
    logic [SW-1:0] w_step_nxt;
    logic [W-1:0]  r_a [N][N];
    logic [W-1:0]  r_b [N][N];
    logic          w_load;
    logic [31:0]   w_t;

    assign w_load = (r_state == S_IDLE) && start_i;
    assign w_t    = 32'(r_step);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_a     <= '{default: '0};
            r_b     <= '{default: '0};
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_load) begin
                r_a <= MatA_i;
                r_b <= MatB_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        last_feed_o = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_state_nxt = S_FEED;
                    w_step_nxt  = '0;
                end
            end
            S_FEED: begin
                valid_o = 1'b1;
                if (r_step == LAST_FEED) begin
                    last_feed_o = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            S_DRAIN: begin
                valid_o = 1'b1;
                if (r_step == LAST_DRAIN) begin
                    w_state_nxt = S_DONE;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane i carries the element whose row+col offset equals the current step.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            a_row_o[i] = '0;
            b_col_o[i] = '0;
        end
        if (r_state == S_FEED) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (w_t == i + k) begin
                        a_row_o[i] = r_a[i][k];
                        b_col_o[i] = r_b[k][i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench: the driver queues one expected output snapshot per cycle of each
// accepted run; the monitor compares every cycle against the queue or the idle pattern.
module tb_systolic_skew_feeder;

    localparam int N = 4;
    localparam int W = 4;

    typedef logic [W-1:0] mat_t [N][N];

    typedef struct packed {
        logic [N-1:0][W-1:0] a;
        logic [N-1:0][W-1:0] b;
        logic                rdy;
        logic                vld;
        logic                last;
        logic                done;
    } snap_t;

    logic         clk_i;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] MatA_i  [N][N];
    logic [W-1:0] MatB_i  [N][N];
    logic         ready_o;
    logic [W-1:0] a_row_o [N];
    logic [W-1:0] b_col_o [N];
    logic         valid_o;
    logic         last_feed_o;
    logic         done_o;

    snap_t q[$];
    int    n_cmp;
    int    n_bad;
    bit    mon_en;
    int    cyc;

    systolic_skew_feeder #(.N(N), .W(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .MatA_i      (MatA_i),
        .MatB_i      (MatB_i),
        .ready_o     (ready_o),
        .a_row_o     (a_row_o),
        .b_col_o     (b_col_o),
        .valid_o     (valid_o),
        .last_feed_o (last_feed_o),
        .done_o      (done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Cycle c of a run is the cycle following the start edge plus c.
    function automatic snap_t exp_snap(input mat_t a, input mat_t b, input int c);
        snap_t s;
        s = '0;
        if (c < 2 * N - 1) begin
            s.vld = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (c - i >= 0 && c - i < N) s.a[i] = a[i][c - i];
                if (c - i >= 0 && c - i < N) s.b[i] = b[c - i][i];
            end
            s.last = (c == 2 * N - 2);
        end else if (c < 3 * N - 1) begin
            s.vld = 1'b1;
        end else begin
            s.done = 1'b1;
        end
        return s;
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            snap_t e;
            snap_t g;
            cyc = cyc + 1;
            for (int i = 0; i < N; i++) begin
                g.a[i] = a_row_o[i];
                g.b[i] = b_col_o[i];
            end
            g.rdy  = ready_o;
            g.vld  = valid_o;
            g.last = last_feed_o;
            g.done = done_o;
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e     = '0;
                e.rdy = 1'b1;
            end
            n_cmp = n_cmp + 1;
            if (g !== e) begin
                n_bad = n_bad + 1;
                $display("FAIL snapshot cyc=%0d got a=%h b=%h rdy=%b vld=%b last=%b done=%b, expected a=%h b=%h rdy=%b vld=%b last=%b done=%b",
                         cyc, g.a, g.b, g.rdy, g.vld, g.last, g.done,
                         e.a, e.b, e.rdy, e.vld, e.last, e.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Entered and left at +1 after an edge with the DUT idle in that cycle.
    task automatic run(input mat_t a, input mat_t b, input bit hold);
        MatA_i  = a;
        MatB_i  = b;
        start_i = 1'b1;
        tick();
        for (int c = 0; c < 3 * N; c++) q.push_back(exp_snap(a, b, c));
        if (!hold) start_i = 1'b0;
        for (int k = 0; k < 3 * N; k++) begin
            tick();
            if (hold) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        MatA_i[i][j] = '1;
                        MatB_i[i][j] = W'($urandom);
                    end
            end
        end
        start_i = 1'b0;
    endtask

    task automatic abort_run(input mat_t a, input mat_t b);
        MatA_i  = a;
        MatB_i  = b;
        start_i = 1'b1;
        tick();
        for (int c = 0; c < 3 * N; c++) q.push_back(exp_snap(a, b, c));
        start_i = 1'b0;
        repeat (4) tick();
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick();
        q.delete();
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (3 * N + 2) tick();
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = W'($urandom);
        return m;
    endfunction

    initial begin
        mat_t ma;
        mat_t mb;
        mat_t mid;
        mat_t mf;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        mon_en  = 1'b0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                MatA_i[i][j] = '0;
                MatB_i[i][j] = '0;
            end
        repeat (3) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;
        repeat (10) tick();

        ma = '{'{4'd0, 4'd2, 4'd3, 4'd4}, '{4'd5, 4'd6, 4'd7, 4'd8},
               '{4'd9, 4'd10, 4'd11, 4'd12}, '{4'd13, 4'd14, 4'd15, 4'd15}};
        mb = '{'{4'd1, 4'd2, 4'd3, 4'd4}, '{4'd5, 4'd6, 4'd7, 4'd8},
               '{4'd9, 4'd10, 4'd11, 4'd12}, '{4'd13, 4'd14, 4'd15, 4'd15}};
        run(ma, mb, 1'b0);
        run(ma, mb, 1'b1);
        run(rand_mat(), rand_mat(), 1'b0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mid[i][j] = (i == j) ? W'(1) : '0;
                mf[i][j]  = '1;
            end
        run(mid, mf, 1'b0);
        tick();

        abort_run(rand_mat(), rand_mat());
        run(ma, mb, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run(rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL queue_drained got %0d pending, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
